// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing and the receiver state encoding.
package uart_pkg;

   localparam int unsigned DEFAULT_CLKS_PER_BIT = 217;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StStart   = 3'd1,
      StData    = 3'd2,
      StStop    = 3'd3,
      StCleanup = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side byte handshake: the received byte and status pulses, plus the FIFO full flag.
interface uart_rx_if;

   logic       full;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;
   logic       o_RX_Active;
   logic       o_Frame_Err;
   logic       o_Overrun;

   // Receiver drives the byte and status, reads back the FIFO full flag
   modport master (
      input  full,
      output o_RX_DV,
      output o_RX_Byte,
      output o_RX_Active,
      output o_Frame_Err,
      output o_Overrun
   );

   // FIFO side consumes the byte and status, reports full
   modport slave (
      output full,
      input  o_RX_DV,
      input  o_RX_Byte,
      input  o_RX_Active,
      input  o_Frame_Err,
      input  o_Overrun
   );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial pin; resets to the idle (high) level.
module uart_sync (
   input  logic i_Clock,
   input  logic rst,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture of the pin, both stages preset to idle-high on reset
   always_ff @(posedge i_Clock) begin
      if (!rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, mid-bit sampling, registered DV / overrun / frame-error pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic      i_Clock,
   input  logic      rst,
   input  logic      i_RX_Serial,
   uart_rx_if.master rx_if
);

   localparam int unsigned      CNT_W   = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] LP_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

   // Fewer than 4 clocks per bit leaves no room for start qualification
   if (CLKS_PER_BIT < 4) begin : g_param_check
      $fatal(1, "uart_rx: CLKS_PER_BIT must be 4 or more");
   end

   logic             w_rx_s;
   rx_state_e        r_state,   w_state_next;
   logic [CNT_W-1:0] r_cnt,     w_cnt_next;
   logic [2:0]       r_bit_idx, w_bit_idx_next;
   logic [7:0]       r_shift,   w_shift_next;
   logic [7:0]       r_byte,    w_byte_next;
   logic             r_dv,      w_dv_next;
   logic             r_ovr,     w_ovr_next;
   logic             r_ferr,    w_ferr_next;
   logic             r_active,  w_active_next;

   uart_sync u_sync (
      .i_Clock (i_Clock),
      .rst     (rst),
      .i_async (i_RX_Serial),
      .o_sync  (w_rx_s)
   );

   // State and datapath registers; pulses are registered so they land one cycle after the sample
   always_ff @(posedge i_Clock) begin
      if (!rst) begin
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_byte    <= '0;
         r_dv      <= 1'b0;
         r_ovr     <= 1'b0;
         r_ferr    <= 1'b0;
         r_active  <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_bit_idx <= w_bit_idx_next;
         r_shift   <= w_shift_next;
         r_byte    <= w_byte_next;
         r_dv      <= w_dv_next;
         r_ovr     <= w_ovr_next;
         r_ferr    <= w_ferr_next;
         r_active  <= w_active_next;
      end
   end

   // Next-state, bit timing, shifting and stop-bit outcome selection
   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_bit_idx_next = r_bit_idx;
      w_shift_next   = r_shift;
      w_byte_next    = r_byte;
      w_dv_next      = 1'b0;
      w_ovr_next     = 1'b0;
      w_ferr_next    = 1'b0;
      w_active_next  = r_active;

      case (r_state)
         StIdle: begin
            w_cnt_next     = '0;
            w_bit_idx_next = '0;
            if (!w_rx_s) begin
               w_state_next  = StStart;
               w_active_next = 1'b1;
            end
         end

         StStart: begin
            if (r_cnt == LP_HALF) begin
               w_cnt_next = '0;
               if (!w_rx_s) begin
                  w_state_next = StData;
               end else begin
                  // Line went back high before mid start bit: glitch
                  w_state_next  = StIdle;
                  w_active_next = 1'b0;
               end
            end else begin
               w_cnt_next = r_cnt + LP_ONE;
            end
         end

         StData: begin
            if (r_cnt == LP_LAST) begin
               w_cnt_next              = '0;
               w_shift_next[r_bit_idx] = w_rx_s;
               if (r_bit_idx == 3'd7) begin
                  w_bit_idx_next = '0;
                  w_state_next   = StStop;
               end else begin
                  w_bit_idx_next = r_bit_idx + 3'd1;
               end
            end else begin
               w_cnt_next = r_cnt + LP_ONE;
            end
         end

         StStop: begin
            if (r_cnt == LP_LAST) begin
               w_cnt_next   = '0;
               w_state_next = StCleanup;
               if (!w_rx_s) begin
                  w_ferr_next = 1'b1;
               end else if (rx_if.full) begin
                  w_ovr_next = 1'b1;
               end else begin
                  w_byte_next = r_shift;
                  w_dv_next   = 1'b1;
               end
            end else begin
               w_cnt_next = r_cnt + LP_ONE;
            end
         end

         StCleanup: begin
            // Wait for the line to return high so a held break cannot retrigger
            if (w_rx_s) begin
               w_state_next  = StIdle;
               w_active_next = 1'b0;
            end
         end

         default: begin
            w_state_next   = StIdle;
            w_cnt_next     = '0;
            w_bit_idx_next = '0;
            w_active_next  = 1'b0;
         end
      endcase
   end

   assign rx_if.o_RX_DV     = r_dv;
   assign rx_if.o_RX_Byte   = r_byte;
   assign rx_if.o_RX_Active = r_active;
   assign rx_if.o_Frame_Err = r_ferr;
   assign rx_if.o_Overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16, 217 and 4 clocks per bit.
module tb_uart_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic rx_line  [3];
   logic full_drv [3];

   uart_rx_if if0 ();
   uart_rx_if if1 ();
   uart_rx_if if2 ();

   assign if0.full = full_drv[0];
   assign if1.full = full_drv[1];
   assign if2.full = full_drv[2];

   uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
      .i_Clock     (clk),
      .rst         (rst_n),
      .i_RX_Serial (rx_line[0]),
      .rx_if       (if0)
   );

   uart_rx #(.CLKS_PER_BIT(217)) u_dut217 (
      .i_Clock     (clk),
      .rst         (rst_n),
      .i_RX_Serial (rx_line[1]),
      .rx_if       (if1)
   );

   uart_rx #(.CLKS_PER_BIT(4)) u_dut4 (
      .i_Clock     (clk),
      .rst         (rst_n),
      .i_RX_Serial (rx_line[2]),
      .rx_if       (if2)
   );

   logic       dv    [3];
   logic       ovr   [3];
   logic       ferr  [3];
   logic       act   [3];
   logic [7:0] rbyte [3];

   assign dv[0] = if0.o_RX_DV;      assign dv[1] = if1.o_RX_DV;      assign dv[2] = if2.o_RX_DV;
   assign ovr[0] = if0.o_Overrun;   assign ovr[1] = if1.o_Overrun;   assign ovr[2] = if2.o_Overrun;
   assign ferr[0] = if0.o_Frame_Err; assign ferr[1] = if1.o_Frame_Err;
   assign ferr[2] = if2.o_Frame_Err;
   assign act[0] = if0.o_RX_Active; assign act[1] = if1.o_RX_Active; assign act[2] = if2.o_RX_Active;
   assign rbyte[0] = if0.o_RX_Byte; assign rbyte[1] = if1.o_RX_Byte; assign rbyte[2] = if2.o_RX_Byte;

   int n_vec = 0;
   int n_err = 0;

   int         dv_cnt   [3] = '{0, 0, 0};
   int         ovr_cnt  [3] = '{0, 0, 0};
   int         ferr_cnt [3] = '{0, 0, 0};
   int         act_cnt  [3] = '{0, 0, 0};
   int         multi_cnt    = 0;
   logic [7:0] got [3][8];

   // Pulse monitor: counts high cycles of each pulse and logs every byte seen with DV
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (dv[i] === 1'b1) begin
            got[i][dv_cnt[i] % 8] <= rbyte[i];
            dv_cnt[i] <= dv_cnt[i] + 1;
         end
         if (ovr[i] === 1'b1) ovr_cnt[i] <= ovr_cnt[i] + 1;
         if (ferr[i] === 1'b1) ferr_cnt[i] <= ferr_cnt[i] + 1;
         if (act[i] === 1'b1) act_cnt[i] <= act_cnt[i] + 1;
         if ((int'(dv[i] === 1'b1) + int'(ovr[i] === 1'b1) + int'(ferr[i] === 1'b1)) > 1)
            multi_cnt <= multi_cnt + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int cpb_of(int sel);
      case (sel)
         0:       return 16;
         1:       return 217;
         default: return 4;
      endcase
   endfunction

   task automatic wait_clks(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(int sel, logic v);
      rx_line[sel] = v;
      repeat (cpb_of(sel)) @(negedge clk);
   endtask

   task automatic send_frame(int sel, logic [7:0] b, logic stop);
      drive_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(sel, b[i]);
      drive_bit(sel, stop);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rx_line[i]  = 1'b1;
         full_drv[i] = 1'b0;
      end
      wait_clks(4);
      for (int i = 0; i < 3; i++) begin
         n_vec++; if (dv[i] !== 1'b0) begin n_err++;
            $display("FAIL reset_dv[%0d] got %b exp 0", i, dv[i]); end
         n_vec++; if (ovr[i] !== 1'b0) begin n_err++;
            $display("FAIL reset_ovr[%0d] got %b exp 0", i, ovr[i]); end
         n_vec++; if (ferr[i] !== 1'b0) begin n_err++;
            $display("FAIL reset_ferr[%0d] got %b exp 0", i, ferr[i]); end
         n_vec++; if (act[i] !== 1'b0) begin n_err++;
            $display("FAIL reset_active[%0d] got %b exp 0", i, act[i]); end
         n_vec++; if (rbyte[i] !== 8'h00) begin n_err++;
            $display("FAIL reset_byte[%0d] got %h exp 00", i, rbyte[i]); end
      end
      rst_n = 1'b1;
      wait_clks(4);
      n_vec++; if (act[0] !== 1'b0) begin n_err++;
         $display("FAIL idle_after_reset got %b exp 0", act[0]); end
   endtask

   task automatic test_single();
      int d0, o0, f0, a0;
      d0 = dv_cnt[0]; o0 = ovr_cnt[0]; f0 = ferr_cnt[0]; a0 = act_cnt[0];
      send_frame(0, 8'hA5, 1'b1);
      wait_clks(4);
      n_vec++; if (dv_cnt[0] !== d0 + 1) begin n_err++;
         $display("FAIL single_dv_count got %0d exp %0d", dv_cnt[0] - d0, 1); end
      n_vec++; if (got[0][d0 % 8] !== 8'hA5) begin n_err++;
         $display("FAIL single_byte_at_dv got %h exp a5", got[0][d0 % 8]); end
      n_vec++; if (rbyte[0] !== 8'hA5) begin n_err++;
         $display("FAIL single_byte_held got %h exp a5", rbyte[0]); end
      n_vec++; if (ovr_cnt[0] !== o0 || ferr_cnt[0] !== f0) begin n_err++;
         $display("FAIL single_no_err got ovr %0d ferr %0d exp 0 0",
                  ovr_cnt[0] - o0, ferr_cnt[0] - f0); end
      n_vec++; if (act_cnt[0] <= a0) begin n_err++;
         $display("FAIL single_active_seen got %0d cycles exp >0", act_cnt[0] - a0); end
      n_vec++; if (act[0] !== 1'b0) begin n_err++;
         $display("FAIL single_active_after got %b exp 0", act[0]); end
   endtask

   task automatic test_back_to_back();
      int d0;
      d0 = dv_cnt[0];
      send_frame(0, 8'h00, 1'b1);
      send_frame(0, 8'hFF, 1'b1);
      send_frame(0, 8'h3C, 1'b1);
      wait_clks(4);
      n_vec++; if (dv_cnt[0] !== d0 + 3) begin n_err++;
         $display("FAIL b2b_dv_count got %0d exp 3", dv_cnt[0] - d0); end
      n_vec++; if (got[0][d0 % 8] !== 8'h00) begin n_err++;
         $display("FAIL b2b_byte0 got %h exp 00", got[0][d0 % 8]); end
      n_vec++; if (got[0][(d0 + 1) % 8] !== 8'hFF) begin n_err++;
         $display("FAIL b2b_byte1 got %h exp ff", got[0][(d0 + 1) % 8]); end
      n_vec++; if (got[0][(d0 + 2) % 8] !== 8'h3C) begin n_err++;
         $display("FAIL b2b_byte2 got %h exp 3c", got[0][(d0 + 2) % 8]); end
   endtask

   task automatic test_glitch();
      int  d0, o0, f0;
      bit  fell;
      d0 = dv_cnt[0]; o0 = ovr_cnt[0]; f0 = ferr_cnt[0];
      rx_line[0] = 1'b0;
      wait_clks(4);
      rx_line[0] = 1'b1;
      fell = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (act[0] === 1'b0) begin
            fell = 1'b1;
            break;
         end
      end
      n_vec++; if (!fell) begin n_err++;
         $display("FAIL glitch_active_drop got %b exp 0 within 10 clks", act[0]); end
      wait_clks(20);
      n_vec++; if (dv_cnt[0] !== d0 || ovr_cnt[0] !== o0 || ferr_cnt[0] !== f0) begin n_err++;
         $display("FAIL glitch_no_pulse got dv %0d ovr %0d ferr %0d exp 0 0 0",
                  dv_cnt[0] - d0, ovr_cnt[0] - o0, ferr_cnt[0] - f0); end
   endtask

   task automatic test_frame_err();
      int d0, o0, f0;
      d0 = dv_cnt[0]; o0 = ovr_cnt[0]; f0 = ferr_cnt[0];
      send_frame(0, 8'h55, 1'b0);
      wait_clks(40);
      n_vec++; if (ferr_cnt[0] !== f0 + 1) begin n_err++;
         $display("FAIL ferr_count got %0d exp 1", ferr_cnt[0] - f0); end
      n_vec++; if (dv_cnt[0] !== d0 || ovr_cnt[0] !== o0) begin n_err++;
         $display("FAIL ferr_no_dv got dv %0d ovr %0d exp 0 0", dv_cnt[0] - d0, ovr_cnt[0] - o0); end
      n_vec++; if (act[0] !== 1'b1) begin n_err++;
         $display("FAIL ferr_held_in_cleanup got active %b exp 1", act[0]); end
      n_vec++; if (rbyte[0] !== 8'h3C) begin n_err++;
         $display("FAIL ferr_byte_kept got %h exp 3c", rbyte[0]); end
      rx_line[0] = 1'b1;
      wait_clks(5);
      n_vec++; if (act[0] !== 1'b0) begin n_err++;
         $display("FAIL ferr_release_idle got active %b exp 0", act[0]); end
      n_vec++; if (ferr_cnt[0] !== f0 + 1 || dv_cnt[0] !== d0) begin n_err++;
         $display("FAIL ferr_no_retrigger got ferr %0d dv %0d exp 1 0",
                  ferr_cnt[0] - f0, dv_cnt[0] - d0); end
   endtask

   task automatic test_overrun();
      int d0, o0, f0;
      d0 = dv_cnt[0]; o0 = ovr_cnt[0]; f0 = ferr_cnt[0];
      full_drv[0] = 1'b1;
      send_frame(0, 8'h81, 1'b1);
      wait_clks(4);
      full_drv[0] = 1'b0;
      n_vec++; if (ovr_cnt[0] !== o0 + 1) begin n_err++;
         $display("FAIL ovr_count got %0d exp 1", ovr_cnt[0] - o0); end
      n_vec++; if (dv_cnt[0] !== d0 || ferr_cnt[0] !== f0) begin n_err++;
         $display("FAIL ovr_no_dv got dv %0d ferr %0d exp 0 0", dv_cnt[0] - d0, ferr_cnt[0] - f0); end
      n_vec++; if (rbyte[0] !== 8'h3C) begin n_err++;
         $display("FAIL ovr_byte_kept got %h exp 3c", rbyte[0]); end
   endtask

   task automatic test_full_ignored();
      int         d0, o0;
      logic [7:0] b;
      b  = 8'h96;
      d0 = dv_cnt[0]; o0 = ovr_cnt[0];
      full_drv[0] = 1'b1;
      drive_bit(0, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(0, b[i]);
      full_drv[0] = 1'b0;
      drive_bit(0, 1'b1);
      wait_clks(4);
      n_vec++; if (dv_cnt[0] !== d0 + 1 || ovr_cnt[0] !== o0) begin n_err++;
         $display("FAIL full_early_ignored got dv %0d ovr %0d exp 1 0",
                  dv_cnt[0] - d0, ovr_cnt[0] - o0); end
      n_vec++; if (rbyte[0] !== 8'h96) begin n_err++;
         $display("FAIL full_early_byte got %h exp 96", rbyte[0]); end
   endtask

   task automatic test_reset_midframe(int sel);
      int         d0, o0, f0, cpb;
      logic [7:0] b;
      b   = 8'h7E;
      cpb = cpb_of(sel);
      d0 = dv_cnt[sel]; o0 = ovr_cnt[sel]; f0 = ferr_cnt[sel];
      drive_bit(sel, 1'b0);
      for (int i = 0; i < 3; i++) drive_bit(sel, b[i]);
      rx_line[sel] = b[3];
      wait_clks(cpb / 2);
      rst_n = 1'b0;
      wait_clks(2);
      n_vec++; if (act[sel] !== 1'b0 || dv[sel] !== 1'b0 || ovr[sel] !== 1'b0 ||
                   ferr[sel] !== 1'b0) begin n_err++;
         $display("FAIL midrst_outputs[%0d] got act %b dv %b ovr %b ferr %b exp 0 0 0 0",
                  sel, act[sel], dv[sel], ovr[sel], ferr[sel]); end
      n_vec++; if (rbyte[sel] !== 8'h00) begin n_err++;
         $display("FAIL midrst_byte[%0d] got %h exp 00", sel, rbyte[sel]); end
      rst_n = 1'b1;
      rx_line[sel] = 1'b1;
      wait_clks(2 * cpb + 4);
      n_vec++; if (dv_cnt[sel] !== d0 || ovr_cnt[sel] !== o0 || ferr_cnt[sel] !== f0) begin
         n_err++;
         $display("FAIL midrst_no_pulse[%0d] got dv %0d ovr %0d ferr %0d exp 0 0 0", sel,
                  dv_cnt[sel] - d0, ovr_cnt[sel] - o0, ferr_cnt[sel] - f0); end
      n_vec++; if (act[sel] !== 1'b0) begin n_err++;
         $display("FAIL midrst_idle[%0d] got active %b exp 0", sel, act[sel]); end
      send_frame(sel, 8'h7E, 1'b1);
      wait_clks(4);
      n_vec++; if (dv_cnt[sel] !== d0 + 1) begin n_err++;
         $display("FAIL midrst_next_dv[%0d] got %0d exp 1", sel, dv_cnt[sel] - d0); end
      n_vec++; if (rbyte[sel] !== 8'h7E) begin n_err++;
         $display("FAIL midrst_next_byte[%0d] got %h exp 7e", sel, rbyte[sel]); end
   endtask

   task automatic test_exclusive();
      n_vec++; if (multi_cnt !== 0) begin n_err++;
         $display("FAIL pulse_exclusive got %0d overlapping cycles exp 0", multi_cnt); end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rx_line[i]  = 1'b1;
         full_drv[i] = 1'b0;
      end
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_full_ignored();
      test_reset_midframe(0);
      test_reset_midframe(1);
      test_reset_midframe(2);
      test_exclusive();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
